// File: rtl/ramcard_mem_arbiter_if.sv
// Request/acknowledge bus shared by the CPU, video and memory sides
// of the RAM card arbiter.
interface ramcard_mem_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              ack;

    modport master (
        output req, we, addr, din,
        input  dout, ack
    );

    modport slave (
        input  req, we, addr, din,
        output dout, ack
    );
endinterface

// File: rtl/ramcard_mem_arbiter.sv
// Single-port RAM arbiter: CPU has priority, video is protected by a
// starvation counter, and a watchdog aborts hung memory transactions.
module ramcard_mem_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 8,
    parameter int VID_MAX_WAIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  reset_in,
    ramcard_mem_arbiter_if.slave  cpu,
    ramcard_mem_arbiter_if.slave  vid,
    ramcard_mem_arbiter_if.master mem,
    output logic                  busy,
    output logic                  err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] VMAX    = 4'(VID_MAX_WAIT);
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t state;
    state_t state_nxt;

    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] cpu_dout_q;
    logic [DATA_W-1:0] vid_dout_q;
    logic [3:0]        starve_q;
    logic [7:0]        wdog_q;
    logic              holdoff_q;
    logic              err_q;

    logic win_vid;
    logic grant;
    logic wd_expire;
    logic mem_on;

    // Arbitration: priority is judged on the raw requests; the holdoff
    // cycle only refuses to re-grant the requester just served.
    always_comb begin
        win_vid   = vid.req & (~cpu.req | (starve_q == VMAX));
        grant     = (state == S_IDLE) & (cpu.req | vid.req)
                  & ~(holdoff_q & (win_vid == owner_q));
        wd_expire = (wdog_q == WD_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a memory ack wins over a same-cycle watchdog expiry.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (grant) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mem.ack || wd_expire) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant latching, starvation counter, watchdog and read-data capture.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            cpu_dout_q <= '0;
            vid_dout_q <= '0;
            starve_q   <= 4'd0;
            wdog_q     <= 8'd0;
            holdoff_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            holdoff_q <= (state == S_DONE);
            if (grant) begin
                owner_q <= win_vid;
                we_q    <= win_vid ? 1'b0 : cpu.we;
                addr_q  <= win_vid ? vid.addr : cpu.addr;
                din_q   <= win_vid ? '0 : cpu.din;
                if (win_vid || !vid.req) begin
                    starve_q <= 4'd0;
                end else if (starve_q != VMAX) begin
                    starve_q <= starve_q + 4'd1;
                end
            end
            if (state == S_ISSUE) begin
                wdog_q <= 8'd0;
            end else if (state == S_WAIT) begin
                wdog_q <= wdog_q + 8'd1;
                if (mem.ack) begin
                    if (owner_q) vid_dout_q <= mem.dout;
                    else         cpu_dout_q <= mem.dout;
                end else if (wd_expire) begin
                    if (owner_q) vid_dout_q <= '1;
                    else         cpu_dout_q <= '1;
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Outputs decoded from the current state and the latched fields.
    always_comb begin
        mem_on      = (state == S_ISSUE) || (state == S_WAIT);
        mem.req     = mem_on;
        mem.we      = we_q & mem_on;
        mem.addr    = addr_q;
        mem.din     = din_q;
        cpu.ack     = (state == S_DONE) & ~owner_q;
        vid.ack     = (state == S_DONE) & owner_q;
        cpu.dout    = cpu_dout_q;
        vid.dout    = vid_dout_q;
        busy        = (state != S_IDLE);
        err_timeout = err_q;
    end

endmodule

// File: tb/tb_ramcard_mem_arbiter.sv
// Directed bench for ramcard_mem_arbiter: latency, arbitration order,
// writes, watchdog abort, mid-transaction reset and spurious acks.
module tb_ramcard_mem_arbiter;

    logic clk;
    logic reset_in;
    logic busy;
    logic err_timeout;

    int checks;
    int failures;

    ramcard_mem_arbiter_if #(.ADDR_W(24), .DATA_W(8)) cpu_if ();
    ramcard_mem_arbiter_if #(.ADDR_W(24), .DATA_W(8)) vid_if ();
    ramcard_mem_arbiter_if #(.ADDR_W(24), .DATA_W(8)) mem_if ();

    ramcard_mem_arbiter #(
        .ADDR_W(24),
        .DATA_W(8),
        .VID_MAX_WAIT(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset_in(reset_in),
        .cpu(cpu_if),
        .vid(vid_if),
        .mem(mem_if),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mreq();
        int n;
        n = 0;
        while (!mem_if.req && n < 20) begin
            tick();
            n++;
        end
        check("mreq_seen", 32'(mem_if.req), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic acc;
        logic exp_vid;
        logic [7:0] d;
        checks   = 0;
        failures = 0;

        reset_in    = 1'b1;
        cpu_if.req  = 1'b0;
        cpu_if.we   = 1'b0;
        cpu_if.addr = '0;
        cpu_if.din  = '0;
        vid_if.req  = 1'b0;
        vid_if.we   = 1'b0;
        vid_if.addr = '0;
        vid_if.din  = '0;
        mem_if.ack  = 1'b0;
        mem_if.dout = '0;
        tick();
        tick();
        check("rst_mreq", 32'(mem_if.req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(mem_if.addr), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        // Test 1: CPU read, mem_ack in cycle 3
        reset_in = 1'b0;
        tick();
        cpu_if.addr = 24'h01D123;
        cpu_if.req  = 1'b1;
        check("t1_c0_mreq", 32'(mem_if.req), 32'd0);
        tick();
        check("t1_c1_mreq", 32'(mem_if.req), 32'd1);
        check("t1_c1_addr", 32'(mem_if.addr), 32'h01D123);
        check("t1_c1_we", 32'(mem_if.we), 32'd0);
        tick();
        check("t1_c2_mreq", 32'(mem_if.req), 32'd1);
        tick();
        check("t1_c3_mreq", 32'(mem_if.req), 32'd1);
        check("t1_c3_ack", 32'(cpu_if.ack), 32'd0);
        mem_if.ack  = 1'b1;
        mem_if.dout = 8'h5A;
        tick();
        mem_if.ack = 1'b0;
        check("t1_c4_ack", 32'(cpu_if.ack), 32'd1);
        check("t1_c4_dout", 32'(cpu_if.dout), 32'h5A);
        check("t1_c4_mreq", 32'(mem_if.req), 32'd0);
        cpu_if.req = 1'b0;
        tick();
        check("t1_c5_ack", 32'(cpu_if.ack), 32'd0);
        check("t1_c5_busy", 32'(busy), 32'd0);

        // Test 2: both held, order CPU x4 then VID, repeating
        cpu_if.addr = 24'h000010;
        vid_if.addr = 24'h100000;
        cpu_if.req  = 1'b1;
        vid_if.req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_vid = ((i % 5) == 4);
            wait_mreq();
            check("t2_addr", 32'(mem_if.addr),
                  exp_vid ? 32'h100000 : 32'h000010);
            tick();
            d = 8'(8'h20 + i);
            mem_if.ack  = 1'b1;
            mem_if.dout = d;
            tick();
            mem_if.ack = 1'b0;
            check("t2_vid_ack", 32'(vid_if.ack), 32'(exp_vid));
            check("t2_cpu_ack", 32'(cpu_if.ack), 32'(!exp_vid));
            check("t2_dout", exp_vid ? 32'(vid_if.dout) : 32'(cpu_if.dout),
                  32'(d));
        end
        cpu_if.req = 1'b0;
        vid_if.req = 1'b0;
        tick();
        tick();
        tick();

        // Test 3: CPU write, fields stable until mem_ack
        cpu_if.we   = 1'b1;
        cpu_if.addr = 24'h020000;
        cpu_if.din  = 8'hA7;
        cpu_if.req  = 1'b1;
        acc = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            acc = acc & mem_if.req & mem_if.we
                & (mem_if.addr == 24'h020000) & (mem_if.din == 8'hA7);
        end
        check("t3_stable", 32'(acc), 32'd1);
        mem_if.ack  = 1'b1;
        mem_if.dout = 8'h3C;
        tick();
        mem_if.ack = 1'b0;
        check("t3_ack", 32'(cpu_if.ack), 32'd1);
        check("t3_dout", 32'(cpu_if.dout), 32'h3C);
        check("t3_we_off", 32'(mem_if.we), 32'd0);
        cpu_if.req = 1'b0;
        cpu_if.we  = 1'b0;
        tick();
        check("t3_single", 32'(cpu_if.ack), 32'd0);
        tick();

        // Test 4: no mem_ack, watchdog of 8 WAIT cycles
        cpu_if.addr = 24'h000100;
        cpu_if.req  = 1'b1;
        acc = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            acc = acc & mem_if.req & ~err_timeout;
        end
        check("t4_wait_len", 32'(acc), 32'd1);
        tick();
        check("t4_mreq_drop", 32'(mem_if.req), 32'd0);
        check("t4_ack", 32'(cpu_if.ack), 32'd1);
        check("t4_dout", 32'(cpu_if.dout), 32'hFF);
        check("t4_err", 32'(err_timeout), 32'd1);
        cpu_if.req = 1'b0;
        tick();
        tick();
        tick();
        check("t4_err_sticky", 32'(err_timeout), 32'd1);

        // Test 5: reset during WAIT
        vid_if.addr = 24'h0ABCDE;
        vid_if.req  = 1'b1;
        tick();
        tick();
        check("t5_in_wait", 32'(mem_if.req), 32'd1);
        reset_in   = 1'b1;
        vid_if.req = 1'b0;
        tick();
        check("t5_mreq", 32'(mem_if.req), 32'd0);
        check("t5_addr", 32'(mem_if.addr), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_err", 32'(err_timeout), 32'd0);
        check("t5_cdout", 32'(cpu_if.dout), 32'd0);
        check("t5_vack", 32'(vid_if.ack), 32'd0);
        reset_in = 1'b0;
        acc = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            acc = acc | vid_if.ack | cpu_if.ack;
        end
        check("t5_no_ack", 32'(acc), 32'd0);
        cpu_if.addr = 24'h000200;
        cpu_if.req  = 1'b1;
        tick();
        tick();
        mem_if.ack  = 1'b1;
        mem_if.dout = 8'h81;
        tick();
        mem_if.ack = 1'b0;
        check("t5_min_ack", 32'(cpu_if.ack), 32'd1);
        check("t5_min_dout", 32'(cpu_if.dout), 32'h81);
        cpu_if.req = 1'b0;
        tick();
        tick();

        // Test 6: vid_req dropped in WAIT, spurious mem_ack in IDLE
        vid_if.addr = 24'h012345;
        vid_if.we   = 1'b1;
        vid_if.req  = 1'b1;
        tick();
        check("t6_we_forced", 32'(mem_if.we), 32'd0);
        check("t6_addr", 32'(mem_if.addr), 32'h012345);
        tick();
        vid_if.req = 1'b0;
        vid_if.we  = 1'b0;
        tick();
        mem_if.ack  = 1'b1;
        mem_if.dout = 8'h6E;
        tick();
        mem_if.ack = 1'b0;
        check("t6_vack", 32'(vid_if.ack), 32'd1);
        check("t6_vdout", 32'(vid_if.dout), 32'h6E);
        tick();
        check("t6_vack_once", 32'(vid_if.ack), 32'd0);
        mem_if.ack  = 1'b1;
        mem_if.dout = 8'h99;
        tick();
        mem_if.ack = 1'b0;
        check("t6_spur_busy", 32'(busy), 32'd0);
        check("t6_spur_ack", 32'(vid_if.ack | cpu_if.ack), 32'd0);
        check("t6_spur_vdout", 32'(vid_if.dout), 32'h6E);
        check("t6_spur_cdout", 32'(cpu_if.dout), 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
